// File: rtl/regfile_mp.sv
// MIPS GPR file: NUM_RD registered read ports, one byte/half/word merge write port, sequential clear engine.
// Read latency 1 cycle; busy=1 during clear, when all accesses are ignored and rd_data reads 0.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [1:0]                 wr_mode,
  input  logic                       clear_req,
  output logic                       busy
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;
  localparam logic [DATA_W-1:0] MASK_B   = {{(DATA_W-8){1'b0}}, 8'hFF};
  localparam logic [DATA_W-1:0] MASK_H   = {{(DATA_W-16){1'b0}}, 16'hFFFF};

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic                clr_we;
  logic                idle;
  logic                clear_take;
  logic                wr_hit;
  logic [DATA_W-1:0]   wr_mask;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rd_val [NUM_RD];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_ptr == LAST_PTR) state_nxt = S_IDLE;
      S_IDLE:  if (clear_req)           state_nxt = S_CLEAR;
      default:                          state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    busy       = (state == S_CLEAR);
    clr_we     = (state == S_CLEAR);
    idle       = (state == S_IDLE);
    clear_take = idle && clear_req;
  end

  // Pointer wraps to 0 on the last clear write, so a later clear_req restarts from register 0.
  always_ff @(posedge clk) begin
    if (!rst_n)      clr_ptr <= '0;
    else if (clr_we) clr_ptr <= clr_ptr + 1'b1;
  end

  always_comb begin
    case (wr_mode)
      2'b01:   wr_mask = MASK_B;
      2'b10:   wr_mask = MASK_H;
      default: wr_mask = '1;
    endcase
    wr_merged = (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    wr_hit    = idle && wr_en && (wr_mode != 2'b11) &&
                !((ZERO_REG != 0) && (wr_addr == '0));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we)      mem[clr_ptr] <= '0;
      else if (wr_hit) mem[wr_addr] <= wr_merged;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
      if ((BYPASS != 0) && wr_hit && (rd_addr[p*ADDR_W +: ADDR_W] == wr_addr))
        rd_val[p] = wr_merged;
      if ((ZERO_REG != 0) && (rd_addr[p*ADDR_W +: ADDR_W] == '0))
        rd_val[p] = '0;
    end
  end

  // Zeroing on clear acceptance keeps rd_data at 0 for every cycle busy is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (busy || clear_take) begin
      rd_data <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++)
        if (rd_en[p]) rd_data[p*DATA_W +: DATA_W] <= rd_val[p];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Random + directed bench for regfile_mp: two instances (zero/bypass on, and both off) against an array model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_mode;
  logic        clear_req;
  logic [63:0] rd_data0;
  logic [63:0] rd_data1;
  logic        busy0;
  logic        busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mode(wr_mode),
    .clear_req(clear_req), .busy(busy0));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mode(wr_mode),
    .clear_req(clear_req), .busy(busy1));

  // Model: index 0 = ZERO_REG=1/BYPASS=1, index 1 = ZERO_REG=0/BYPASS=0.
  logic [31:0] mm     [2][32];
  logic [31:0] exp_rd [2][2];
  bit          m_busy;
  int          m_cnt;
  bit          chk_on = 1'b0;
  logic [31:0] m_old;
  logic [31:0] m_nv;
  bit          m_we;
  logic [4:0]  m_a;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      for (int c = 0; c < 2; c++) for (int p = 0; p < 2; p++) exp_rd[c][p] = 32'h0;
      chk_on = 1'b1;
    end else if (m_busy) begin
      m_cnt++;
      for (int c = 0; c < 2; c++) for (int p = 0; p < 2; p++) exp_rd[c][p] = 32'h0;
      if (m_cnt == 32) begin
        m_busy = 1'b0;
        for (int c = 0; c < 2; c++) for (int r = 0; r < 32; r++) mm[c][r] = 32'h0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_old = mm[c][wr_addr];
        case (wr_mode)
          2'd0:    m_nv = wr_data;
          2'd1:    m_nv = {m_old[31:8], wr_data[7:0]};
          default: m_nv = {m_old[31:16], wr_data[15:0]};
        endcase
        m_we = wr_en && (wr_mode != 2'd3) && !((c == 0) && (wr_addr == 5'd0));
        for (int p = 0; p < 2; p++) begin
          m_a = rd_addr[p*5 +: 5];
          if (clear_req)                              exp_rd[c][p] = 32'h0;
          else if (rd_en[p]) begin
            if ((c == 0) && (m_a == 5'd0))            exp_rd[c][p] = 32'h0;
            else if ((c == 0) && m_we && m_a == wr_addr) exp_rd[c][p] = m_nv;
            else                                      exp_rd[c][p] = mm[c][m_a];
          end
        end
        if (m_we) mm[c][wr_addr] = m_nv;
      end
      if (clear_req) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("u0_rd%0d", p), rd_data0[p*32 +: 32], exp_rd[0][p]);
        check($sformatf("u1_rd%0d", p), rd_data1[p*32 +: 32], exp_rd[1][p]);
      end
      check("u0_busy", {31'h0, busy0}, {31'h0, m_busy});
      check("u1_busy", {31'h0, busy1}, {31'h0, m_busy});
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] wm, input logic [1:0] re, input logic [4:0] a0,
                       input logic [4:0] a1, input logic cr);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    wr_mode   = wm;
    rd_en     = re;
    rd_addr   = {a1, a0};
    clear_req = cr;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic count_busy();
    int cnt;
    cnt = 0;
    while (busy0 && cnt < 100) begin
      cnt++;
      idle_cycle();
    end
    check("busy_len", 32'(cnt), 32'd32);
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_mode   = '0;
    rd_en     = '0;
    rd_addr   = '0;
    clear_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rd", rd_data0[31:0], 32'h0);
    check("reset_busy", {31'h0, busy0}, 32'h1);
    rst_n = 1'b1;
    count_busy();

    for (int r = 0; r < 32; r += 2) begin
      drive(1'b0, 5'd0, 32'h0, 2'd0, 2'b11, 5'(r), 5'(r + 1), 1'b0);
      check("clr_u1_p0", rd_data1[31:0], 32'h0);
      check("clr_u1_p1", rd_data1[63:32], 32'h0);
    end

    drive(1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'b01, 5'd5, 5'd0, 1'b0);
    check("word_u0", rd_data0[31:0], 32'hDEADBEEF);
    check("word_u1", rd_data1[31:0], 32'hDEADBEEF);
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'b00, 5'd7, 5'd0, 1'b0);
    check("hold_u0", rd_data0[31:0], 32'hDEADBEEF);

    drive(1'b1, 5'd5, 32'h00000012, 2'd1, 2'b00, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'b10, 5'd0, 5'd5, 1'b0);
    check("byte_u0", rd_data0[63:32], 32'hDEADBE12);
    drive(1'b1, 5'd5, 32'h00003456, 2'd2, 2'b00, 5'd0, 5'd0, 1'b0);
    drive(1'b1, 5'd5, 32'hFFFFFFFF, 2'd3, 2'b01, 5'd5, 5'd0, 1'b0);
    check("half_u0", rd_data0[31:0], 32'hDEAD3456);
    check("mode3_u1", rd_data1[31:0], 32'hDEAD3456);

    drive(1'b1, 5'd7, 32'h00000011, 2'd0, 2'b11, 5'd7, 5'd7, 1'b0);
    check("byp_u0_p0", rd_data0[31:0], 32'h11);
    check("byp_u0_p1", rd_data0[63:32], 32'h11);
    check("nobyp_u1_p0", rd_data1[31:0], 32'h0);
    check("nobyp_u1_p1", rd_data1[63:32], 32'h0);
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'b01, 5'd7, 5'd0, 1'b0);
    check("late_u1", rd_data1[31:0], 32'h11);

    drive(1'b1, 5'd0, 32'hFFFFFFFF, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'b11, 5'd0, 5'd0, 1'b0);
    check("zero_u0", rd_data0[31:0], 32'h0);
    check("nozero_u1", rd_data1[63:32], 32'hFFFFFFFF);

    drive(1'b1, 5'd9, 32'h5, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'b01, 5'd9, 5'd0, 1'b0);
    check("r9_pre", rd_data0[31:0], 32'h5);
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd9, 32'h77, 2'd0, 2'b11, 5'd9, 5'd9, 1'b0);
      check("busy_rd", rd_data0[31:0], 32'h0);
      check("busy_hi", {31'h0, busy1}, 32'h1);
    end
    rst_n = 1'b0;
    idle_cycle();
    idle_cycle();
    rst_n = 1'b1;
    count_busy();
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'b11, 5'd9, 5'd0, 1'b0);
    check("r9_post", rd_data0[31:0], 32'h0);
    check("r0_post_u1", rd_data1[63:32], 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] wa;
      logic [4:0] a0;
      logic [4:0] a1;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), a0, a1, ($urandom_range(0, 199) == 0));
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
